// File: rtl/debug_regfile_dump_ctrl_pkg.sv
// Shared types and constants for the register-file dump path.
// FSM encodings, stream geometry and reset values.
package debug_regfile_dump_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_NEXT = 2'd3
  } dump_state_e;

  localparam int NB_DATA_DEF    = 32;
  localparam int NB_REG_DEF     = 5;
  localparam int SIZE_REG_DEF   = 32;
  localparam int NB_BYTE        = 8;
  localparam int BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE;

  localparam dump_state_e RST_STATE = ST_IDLE;
  localparam logic        RST_BUSY  = 1'b0;
  localparam logic        RST_DONE  = 1'b0;
  localparam logic        RST_VALID = 1'b0;

endpackage

// File: rtl/debug_word_serializer.sv
// Word-to-byte serializer, LSB first, valid/ready output.
// Flags the cycle in which the last byte of a word is accepted.
module debug_word_serializer
  import debug_regfile_dump_ctrl_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  input  logic               i_ready,
  output logic [NB_BYTE-1:0] o_data,
  output logic               o_valid,
  output logic               o_last_acc
);

  localparam int BPW = NB_DATA / NB_BYTE;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] LAST = CW'(BPW - 1);

  logic [NB_DATA-1:0] word_q, word_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               xfer;
  logic               last;

  assign xfer = valid_q & i_ready;
  assign last = (cnt_q == LAST);

  // load, shift after each accepted byte, drop valid after the last
  always_comb begin
    word_d  = word_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (i_clear) begin
      word_d  = '0;
      cnt_d   = '0;
      valid_d = RST_VALID;
    end else if (i_load) begin
      word_d  = i_word;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (xfer) begin
      if (last) begin
        word_d  = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
      end else begin
        word_d = word_q >> NB_BYTE;
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  // serializer state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= RST_VALID;
    end else begin
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign o_data     = word_q[NB_BYTE-1:0];
  assign o_valid    = valid_q;
  assign o_last_acc = xfer & last & ~i_clear;

endmodule

// File: rtl/debug_regfile_dump_ctrl.sv
// Dumps every register-file word as a byte stream.
// Keeps the pipeline halted for the whole dump.
module debug_regfile_dump_ctrl
  import debug_regfile_dump_ctrl_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter int SIZE_REG = 32,
  parameter int NB_BYTE  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pipeline_halt,
  output logic [NB_REG-1:0]  o_address_read_debug,
  input  logic [NB_DATA-1:0] i_data_read_debug,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready
);

  localparam logic [NB_REG-1:0] LAST_ADDR = NB_REG'(SIZE_REG - 1);

  dump_state_e       state_q, state_d;
  logic [NB_REG-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ser_load;
  logic              ser_clear;
  logic              ser_last;

  // next state, address walk, busy and done
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ser_load  = 1'b0;
    ser_clear = 1'b0;
    if (i_abort) begin
      state_d   = ST_IDLE;
      addr_d    = '0;
      busy_d    = RST_BUSY;
      ser_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d = ST_READ;
            busy_d  = 1'b1;
            addr_d  = '0;
          end
        end
        ST_READ: begin
          ser_load = 1'b1;
          state_d  = ST_SEND;
        end
        ST_SEND: begin
          if (ser_last) begin
            if (addr_q == LAST_ADDR) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              addr_d  = '0;
            end else begin
              state_d = ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_READ;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // control registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RST_STATE;
      addr_q  <= '0;
      busy_q  <= RST_BUSY;
      done_q  <= RST_DONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  debug_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (ser_clear),
    .i_load     (ser_load),
    .i_word     (i_data_read_debug),
    .i_ready    (i_tx_ready),
    .o_data     (o_tx_data),
    .o_valid    (o_tx_valid),
    .o_last_acc (ser_last)
  );

  assign o_busy               = busy_q;
  assign o_pipeline_halt      = busy_q;
  assign o_done               = done_q;
  assign o_address_read_debug = addr_q;

endmodule

// File: tb/tb_debug_regfile_dump_ctrl.sv
// Scoreboard bench for the register-file dump sequencer.
// Main 32-register instance plus a 4-register build.
module tb_debug_regfile_dump_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, ready;
  logic       busy, done, halt, txv;
  logic [4:0] addr;
  logic [7:0] txd;
  logic [31:0] rdata;

  logic       start2, abort2, ready2;
  logic       busy2, done2, halt2, txv2;
  logic [4:0] addr2;
  logic [7:0] txd2;
  logic [31:0] rdata2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_mode = 0;
  int popped = 0, popped2 = 0;
  int done_cnt = 0, done_cnt2 = 0;
  int s_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rdata  = 32'hA500_0000 + {27'd0, addr};
  assign rdata2 = 32'hA500_0000 + {27'd0, addr2};
  assign abort2 = 1'b0;
  assign ready2 = 1'b1;

  debug_regfile_dump_ctrl dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_start              (start),
    .i_abort              (abort),
    .o_busy               (busy),
    .o_done               (done),
    .o_pipeline_halt      (halt),
    .o_address_read_debug (addr),
    .i_data_read_debug    (rdata),
    .o_tx_data            (txd),
    .o_tx_valid           (txv),
    .i_tx_ready           (ready)
  );

  debug_regfile_dump_ctrl #(.SIZE_REG(4)) dut4 (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_start              (start2),
    .i_abort              (abort2),
    .o_busy               (busy2),
    .o_done               (done2),
    .o_pipeline_halt      (halt2),
    .o_address_read_debug (addr2),
    .i_data_read_debug    (rdata2),
    .o_tx_data            (txd2),
    .o_tx_valid           (txv2),
    .i_tx_ready           (ready2)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push_main(input int n);
    logic [31:0] w;
    for (int k = 0; k < n; k++) begin
      w = 32'hA500_0000 + k;
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(w >> (8 * b)));
    end
  endfunction

  // ready: tied high, or high one cycle in three
  always @(posedge clk) begin
    #1;
    ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
  end

  // monitor for the main instance
  always @(negedge clk) begin
    if (rst_n) begin
      chk("halt_eq_busy", {31'd0, halt}, {31'd0, busy});
      if (stall_prev) begin
        chk("valid_held", {31'd0, txv}, 32'd1);
        chk("stall_stable", {24'd0, txd}, {24'd0, prev_data});
      end
      if (txv && ready && !abort) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %h expected none", txd);
        end else begin
          chk("byte", {24'd0, txd}, {24'd0, exp_q.pop_front()});
        end
        popped++;
      end
      if (done) done_cnt++;
      stall_prev = txv && !ready && !abort;
      prev_data  = txd;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // monitor for the 4-register instance
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy2) chk("small_addr_max", {31'd0, (addr2 <= 5'd3)}, 32'd1);
      if (txv2) begin
        if (exp2_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL small_extra: got %h expected none", txd2);
        end else begin
          chk("small_byte", {24'd0, txd2}, {24'd0, exp2_q.pop_front()});
        end
        popped2++;
      end
      if (done2) done_cnt2++;
    end
  end

  task automatic check_idle(input string tag, input bit with_data);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_halt"}, {31'd0, halt}, 32'd0);
    chk({tag, "_addr"}, {27'd0, addr}, 32'd0);
    chk({tag, "_valid"}, {31'd0, txv}, 32'd0);
    if (with_data) chk({tag, "_data"}, {24'd0, txd}, 32'd0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_valid0", {31'd0, txv}, 32'd0);
    @(posedge clk); #1;
    chk("start_valid1", {31'd0, txv}, 32'd1);
  endtask

  task automatic wait_done(input string tag, output int dcyc);
    bit got;
    got = 1'b0;
    dcyc = -1;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        dcyc = cyc;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done", tag);
    end
  endtask

  task automatic run_dump(input string tag, input bit timed);
    int dcyc, dc0;
    exp_q.delete();
    popped = 0;
    dc0 = done_cnt;
    push_main(32);
    pulse_start();
    wait_done(tag, dcyc);
    if (timed) chk({tag, "_latency"}, dcyc - s_cyc, 32'd192);
    repeat (2) @(negedge clk);
    chk({tag, "_done_once"}, done_cnt - dc0, 32'd1);
    chk({tag, "_bytes"}, popped, 32'd128);
    chk({tag, "_q_empty"}, exp_q.size(), 32'd0);
    check_idle({tag, "_end"}, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int dc0, dcyc;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    start2 = 1'b0;
    ready  = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_idle("reset", 1'b1);
    rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    check_idle("no_start", 1'b1);

    ready_mode = 0;
    run_dump("full", 1'b1);

    ready_mode = 1;
    run_dump("bp", 1'b0);
    ready_mode = 0;
    repeat (3) @(posedge clk);

    exp_q.delete();
    popped = 0;
    dc0 = done_cnt;
    push_main(32);
    pulse_start();
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(posedge clk); #1;
      if (popped == 30 && txv) found = 1'b1;
    end
    if (found) begin
      chk("abort_addr", {27'd0, addr}, 32'd7);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check_idle("abort", 1'b1);
      repeat (3) @(negedge clk);
      chk("abort_no_done", done_cnt - dc0, 32'd0);
      chk("abort_bytes", popped, 32'd30);
    end else begin
      checks++;
      errors++;
      $display("FAIL abort_timeout: got no point expected addr7 byte2");
    end

    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", {31'd0, busy}, 32'd0);
    run_dump("restart", 1'b1);

    exp_q.delete();
    push_main(32);
    pulse_start();
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(posedge clk); #1;
      if (addr == 5'd12) found = 1'b1;
    end
    chk("rst_reach_12", {31'd0, found}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("rst_async", 1'b1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    exp_q.delete();
    popped = 0;
    dc0 = done_cnt;
    push_main(32);
    pulse_start();
    repeat (50) @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start", dcyc);
    repeat (20) @(negedge clk);
    chk("busy_start_done", done_cnt - dc0, 32'd1);
    chk("busy_start_bytes", popped, 32'd128);
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

    exp2_q.delete();
    popped2 = 0;
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 4; b++)
        exp2_q.push_back(8'((32'hA500_0000 + k) >> (8 * b)));
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      @(negedge clk);
      if (done2) found = 1'b1;
    end
    chk("small_done_seen", {31'd0, found}, 32'd1);
    repeat (3) @(negedge clk);
    chk("small_bytes", popped2, 32'd16);
    chk("small_q_empty", exp2_q.size(), 32'd0);
    chk("small_done_once", done_cnt2, 32'd1);
    chk("small_idle", {31'd0, busy2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
